// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: writeback select codes and
// the memory-stage state encoding.
package mips_pkg;

  localparam logic [1:0] WB_SEL_ALU = 2'd0;
  localparam logic [1:0] WB_SEL_MEM = 2'd1;
  localparam logic [1:0] WB_SEL_PC4 = 2'd2;
  localparam logic [1:0] WB_SEL_IMM = 2'd3;

  typedef enum logic {
    IDLE     = 1'b0,
    MEM_WAIT = 1'b1
  } mem_state_e;

endpackage

// File: rtl/dmem_timeout_ctr.sv
// Counts request cycles without ack and flags the cycle on which
// the TIMEOUT_CYCLES-th unanswered request cycle completes.
module dmem_timeout_ctr
  import mips_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic inc_i,
  output logic expire_o
);

  localparam int W = $clog2(TIMEOUT_CYCLES + 1);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  assign expire_o = inc_i &
    (cnt_q == W'(TIMEOUT_CYCLES - 1));

  // Next count: clear on entry, step on each unanswered cycle.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/mem_wb_stage.sv
// MIPS memory stage feeding the 4:1 writeback mux.
// Optional request timeout: define MIPS_MEM_TIMEOUT_EN.
module mem_wb_stage
  import mips_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_alu_result,
  input  logic [31:0] in_store_data,
  input  logic [31:0] in_pc_plus4,
  input  logic [31:0] in_imm_upper,
  input  logic [1:0]  in_wb_sel,
  input  logic        in_mem_read,
  input  logic        in_mem_write,
  input  logic        in_reg_write,
  input  logic [4:0]  in_rd,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic        out_valid,
  output logic [31:0] out_alu,
  output logic [31:0] out_mem,
  output logic [31:0] out_pc4,
  output logic [31:0] out_imm,
  output logic [1:0]  out_sel,
  output logic        out_reg_write,
  output logic [4:0]  out_rd,
  output logic        mem_err
);

  mem_state_e  state_q, state_d;
  logic        valid_q, valid_d;
  logic [31:0] alu_q, alu_d;
  logic [31:0] mem_q, mem_d;
  logic [31:0] pc4_q, pc4_d;
  logic [31:0] imm_q, imm_d;
  logic [1:0]  sel_q, sel_d;
  logic        rw_q, rw_d;
  logic [4:0]  rd_q, rd_d;
  logic        req_q, req_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        load_q, load_d;
  logic        rwp_q, rwp_d;
  logic        accept;
  logic        mem_op;
  logic        expire;

  assign in_ready = (state_q == IDLE);
  assign accept   = in_valid & in_ready;
  assign mem_op   = in_mem_read | in_mem_write;

`ifdef MIPS_MEM_TIMEOUT_EN
  logic err_q, err_d;
  logic to_clr;
  logic to_inc;

  assign to_clr = accept & mem_op;
  assign to_inc = (state_q == MEM_WAIT) & ~dmem_ack;

  dmem_timeout_ctr #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_to (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr_i   (to_clr),
    .inc_i   (to_inc),
    .expire_o(expire)
  );

  assign mem_err = err_q;
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT_CYCLES != 0);
  assign expire  = 1'b0;
  assign mem_err = 1'b0;
`endif

  // Next-state: accept, launch memory access, retire on ack.
  always_comb begin
    state_d = state_q;
    valid_d = 1'b0;
    rw_d    = 1'b0;
    alu_d   = alu_q;
    mem_d   = mem_q;
    pc4_d   = pc4_q;
    imm_d   = imm_q;
    sel_d   = sel_q;
    rd_d    = rd_q;
    req_d   = req_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    load_d  = load_q;
    rwp_d   = rwp_q;
`ifdef MIPS_MEM_TIMEOUT_EN
    err_d   = err_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          alu_d = in_alu_result;
          pc4_d = in_pc_plus4;
          imm_d = in_imm_upper;
          sel_d = in_wb_sel;
          rd_d  = in_rd;
          mem_d = '0;
          if (mem_op) begin
            req_d   = 1'b1;
            we_d    = in_mem_write;
            addr_d  = in_alu_result;
            wdata_d = in_store_data;
            load_d  = in_mem_read & ~in_mem_write;
            rwp_d   = in_reg_write;
            state_d = MEM_WAIT;
          end else begin
            valid_d = 1'b1;
            rw_d    = in_reg_write;
          end
        end
      end
      MEM_WAIT: begin
        if (dmem_ack) begin
          req_d   = 1'b0;
          mem_d   = load_q ? dmem_rdata : '0;
          valid_d = 1'b1;
          rw_d    = rwp_q;
          state_d = IDLE;
        end else if (expire) begin
          req_d   = 1'b0;
          valid_d = 1'b1;
          rw_d    = 1'b0;
          state_d = IDLE;
`ifdef MIPS_MEM_TIMEOUT_EN
          err_d   = 1'b1;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers, synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      valid_q <= 1'b0;
      rw_q    <= 1'b0;
      alu_q   <= '0;
      mem_q   <= '0;
      pc4_q   <= '0;
      imm_q   <= '0;
      sel_q   <= '0;
      rd_q    <= '0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      load_q  <= 1'b0;
      rwp_q   <= 1'b0;
`ifdef MIPS_MEM_TIMEOUT_EN
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      rw_q    <= rw_d;
      alu_q   <= alu_d;
      mem_q   <= mem_d;
      pc4_q   <= pc4_d;
      imm_q   <= imm_d;
      sel_q   <= sel_d;
      rd_q    <= rd_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      load_q  <= load_d;
      rwp_q   <= rwp_d;
`ifdef MIPS_MEM_TIMEOUT_EN
      err_q   <= err_d;
`endif
    end
  end

  assign out_valid     = valid_q;
  assign out_reg_write = rw_q;
  assign out_alu       = alu_q;
  assign out_mem       = mem_q;
  assign out_pc4       = pc4_q;
  assign out_imm       = imm_q;
  assign out_sel       = sel_q;
  assign out_rd        = rd_q;
  assign dmem_req      = req_q;
  assign dmem_we       = we_q;
  assign dmem_addr     = addr_q;
  assign dmem_wdata    = wdata_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed bench for mem_wb_stage.
// Timeout scenario runs when MIPS_MEM_TIMEOUT_EN is defined.
module tb_mem_wb_stage;
  import mips_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_alu_result;
  logic [31:0] in_store_data;
  logic [31:0] in_pc_plus4;
  logic [31:0] in_imm_upper;
  logic [1:0]  in_wb_sel;
  logic        in_mem_read;
  logic        in_mem_write;
  logic        in_reg_write;
  logic [4:0]  in_rd;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;
  logic        out_valid;
  logic [31:0] out_alu;
  logic [31:0] out_mem;
  logic [31:0] out_pc4;
  logic [31:0] out_imm;
  logic [1:0]  out_sel;
  logic        out_reg_write;
  logic [4:0]  out_rd;
  logic        mem_err;

  int n_cmp = 0;
  int n_bad = 0;

  mem_wb_stage #(.TIMEOUT_CYCLES(8)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_alu_result(in_alu_result),
    .in_store_data(in_store_data),
    .in_pc_plus4  (in_pc_plus4),
    .in_imm_upper (in_imm_upper),
    .in_wb_sel    (in_wb_sel),
    .in_mem_read  (in_mem_read),
    .in_mem_write (in_mem_write),
    .in_reg_write (in_reg_write),
    .in_rd        (in_rd),
    .dmem_req     (dmem_req),
    .dmem_we      (dmem_we),
    .dmem_addr    (dmem_addr),
    .dmem_wdata   (dmem_wdata),
    .dmem_ack     (dmem_ack),
    .dmem_rdata   (dmem_rdata),
    .out_valid    (out_valid),
    .out_alu      (out_alu),
    .out_mem      (out_mem),
    .out_pc4      (out_pc4),
    .out_imm      (out_imm),
    .out_sel      (out_sel),
    .out_reg_write(out_reg_write),
    .out_rd       (out_rd),
    .mem_err      (mem_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] a,
                       input logic [31:0] sd, input logic [1:0] sel,
                       input logic mr, input logic mw,
                       input logic rw, input logic [4:0] rd);
    in_valid      = v;
    in_alu_result = a;
    in_store_data = sd;
    in_pc_plus4   = a + 32'd4;
    in_imm_upper  = {a[15:0], 16'h0};
    in_wb_sel     = sel;
    in_mem_read   = mr;
    in_mem_write  = mw;
    in_reg_write  = rw;
    in_rd         = rd;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    dmem_ack = 1'b0;
    dmem_rdata = '0;
    drive(1'b0, 32'h0, 32'h0, 2'd0, 1'b0, 1'b0, 1'b0, 5'd0);
    tick();
    tick();
    n_cmp++;
    if ({out_valid, out_reg_write, dmem_req, dmem_we, mem_err} !== 5'b0) begin
      n_bad++;
      $display("FAIL reset_flags: got %b want 00000",
               {out_valid, out_reg_write, dmem_req, dmem_we, mem_err});
    end
    n_cmp++;
    if ({out_alu, out_mem, out_pc4, out_imm, dmem_addr, dmem_wdata} !== '0) begin
      n_bad++;
      $display("FAIL reset_data: got nonzero data want 0");
    end
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_ready: got %b want 1", in_ready);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_alu_op();
    drive(1'b1, 32'h10, 32'h0, WB_SEL_ALU, 1'b0, 1'b0, 1'b1, 5'd5);
    tick();
    drive(1'b0, 32'h0, 32'h0, 2'd0, 1'b0, 1'b0, 1'b0, 5'd0);
    n_cmp++;
    if ({out_valid, out_reg_write} !== 2'b11) begin
      n_bad++;
      $display("FAIL alu_pulse: got %b want 11", {out_valid, out_reg_write});
    end
    n_cmp++;
    if (out_alu !== 32'h10 || out_sel !== 2'd0 || out_rd !== 5'd5) begin
      n_bad++;
      $display("FAIL alu_data: got %h/%0d/%0d want 10/0/5",
               out_alu, out_sel, out_rd);
    end
    n_cmp++;
    if (out_pc4 !== 32'h14 || out_imm !== 32'h00100000 || out_mem !== 32'h0) begin
      n_bad++;
      $display("FAIL alu_cand: got %h/%h/%h want 14/00100000/0",
               out_pc4, out_imm, out_mem);
    end
    tick();
    n_cmp++;
    if ({out_valid, out_reg_write} !== 2'b00 || out_alu !== 32'h10) begin
      n_bad++;
      $display("FAIL alu_after: got %b %h want 00 10",
               {out_valid, out_reg_write}, out_alu);
    end
  endtask

  task automatic test_load_wait();
    int reqs;
    reqs = 0;
    drive(1'b1, 32'h100, 32'h0, WB_SEL_MEM, 1'b1, 1'b0, 1'b1, 5'd7);
    tick();
    drive(1'b0, 32'h0, 32'h0, 2'd0, 1'b0, 1'b0, 1'b0, 5'd0);
    n_cmp++;
    if (dmem_addr !== 32'h100 || dmem_we !== 1'b0 || out_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL ld_issue: got addr %h we %b v %b want 100 0 0",
               dmem_addr, dmem_we, out_valid);
    end
    for (int i = 0; i < 3; i++) begin
      if (dmem_req === 1'b1) reqs++;
      n_cmp++;
      if (in_ready !== 1'b0) begin
        n_bad++;
        $display("FAIL ld_ready: got %b want 0", in_ready);
      end
      if (i == 2) begin
        dmem_ack = 1'b1;
        dmem_rdata = 32'hDEADBEEF;
      end
      tick();
    end
    dmem_ack = 1'b0;
    dmem_rdata = 32'h0;
    n_cmp++;
    if (reqs !== 3 || dmem_req !== 1'b0) begin
      n_bad++;
      $display("FAIL ld_req_len: got %0d req %b want 3 0", reqs, dmem_req);
    end
    n_cmp++;
    if ({out_valid, out_reg_write} !== 2'b11 || out_mem !== 32'hDEADBEEF) begin
      n_bad++;
      $display("FAIL ld_data: got %b %h want 11 deadbeef",
               {out_valid, out_reg_write}, out_mem);
    end
    n_cmp++;
    if (out_sel !== WB_SEL_MEM || out_rd !== 5'd7 || out_alu !== 32'h100) begin
      n_bad++;
      $display("FAIL ld_ctl: got %0d %0d %h want 1 7 100",
               out_sel, out_rd, out_alu);
    end
    tick();
    n_cmp++;
    if (out_valid !== 1'b0 || dmem_req !== 1'b0) begin
      n_bad++;
      $display("FAIL ld_after: got v %b req %b want 0 0", out_valid, dmem_req);
    end
  endtask

  task automatic test_store_fast();
    drive(1'b1, 32'h104, 32'h12345678, WB_SEL_ALU, 1'b0, 1'b1, 1'b0, 5'd0);
    tick();
    drive(1'b0, 32'h0, 32'h0, 2'd0, 1'b0, 1'b0, 1'b0, 5'd0);
    n_cmp++;
    if ({dmem_req, dmem_we} !== 2'b11 || dmem_wdata !== 32'h12345678 ||
        dmem_addr !== 32'h104) begin
      n_bad++;
      $display("FAIL st_issue: got %b %h %h want 11 12345678 104",
               {dmem_req, dmem_we}, dmem_wdata, dmem_addr);
    end
    dmem_ack = 1'b1;
    dmem_rdata = 32'hAAAA5555;
    tick();
    dmem_ack = 1'b0;
    n_cmp++;
    if (out_valid !== 1'b1 || out_mem !== 32'h0 || dmem_req !== 1'b0 ||
        out_reg_write !== 1'b0) begin
      n_bad++;
      $display("FAIL st_done: got v %b mem %h req %b rw %b want 1 0 0 0",
               out_valid, out_mem, dmem_req, out_reg_write);
    end
    tick();
  endtask

  task automatic test_rw_both();
    drive(1'b1, 32'h302, 32'hCAFE0001, WB_SEL_MEM, 1'b1, 1'b1, 1'b1, 5'd9);
    tick();
    drive(1'b0, 32'h0, 32'h0, 2'd0, 1'b0, 1'b0, 1'b0, 5'd0);
    n_cmp++;
    if (dmem_we !== 1'b1 || dmem_addr !== 32'h302) begin
      n_bad++;
      $display("FAIL both_we: got %b %h want 1 302", dmem_we, dmem_addr);
    end
    dmem_ack = 1'b1;
    dmem_rdata = 32'h0000FFFF;
    tick();
    dmem_ack = 1'b0;
    n_cmp++;
    if (out_valid !== 1'b1 || out_mem !== 32'h0) begin
      n_bad++;
      $display("FAIL both_mem: got %b %h want 1 0", out_valid, out_mem);
    end
    tick();
  endtask

  task automatic test_idle_ack();
    dmem_ack = 1'b1;
    dmem_rdata = 32'h77777777;
    tick();
    tick();
    dmem_ack = 1'b0;
    n_cmp++;
    if (out_valid !== 1'b0 || dmem_req !== 1'b0 || in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL idle_ack: got v %b req %b rdy %b want 0 0 1",
               out_valid, dmem_req, in_ready);
    end
  endtask

  task automatic test_reset_wait();
    drive(1'b1, 32'h200, 32'h0, WB_SEL_MEM, 1'b1, 1'b0, 1'b1, 5'd3);
    tick();
    drive(1'b0, 32'h0, 32'h0, 2'd0, 1'b0, 1'b0, 1'b0, 5'd0);
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    n_cmp++;
    if (dmem_req !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL rstw_state: got req %b v %b rdy %b want 0 0 1",
               dmem_req, out_valid, in_ready);
    end
    dmem_ack = 1'b1;
    dmem_rdata = 32'h99999999;
    tick();
    dmem_ack = 1'b0;
    n_cmp++;
    if (out_valid !== 1'b0 || out_mem !== 32'h0) begin
      n_bad++;
      $display("FAIL rstw_late_ack: got %b %h want 0 0", out_valid, out_mem);
    end
    drive(1'b1, 32'h55, 32'h0, WB_SEL_ALU, 1'b0, 1'b0, 1'b1, 5'd6);
    tick();
    drive(1'b0, 32'h0, 32'h0, 2'd0, 1'b0, 1'b0, 1'b0, 5'd0);
    n_cmp++;
    if (out_valid !== 1'b1 || out_alu !== 32'h55 || out_rd !== 5'd6) begin
      n_bad++;
      $display("FAIL rstw_next: got %b %h %0d want 1 55 6",
               out_valid, out_alu, out_rd);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [31:0] a;
    for (int i = 0; i < 4; i++) begin
      a = 32'hA0 + 32'(i);
      drive(1'b1, a, 32'h0, 2'(i), 1'b0, 1'b0, 1'b1, 5'(i + 1));
      tick();
      n_cmp++;
      if (out_valid !== 1'b1 || out_sel !== 2'(i) || out_alu !== a ||
          out_pc4 !== a + 32'd4 || out_rd !== 5'(i + 1) ||
          in_ready !== 1'b1) begin
        n_bad++;
        $display("FAIL b2b_%0d: got v %b sel %0d alu %h pc4 %h rd %0d want 1 %0d %h %h %0d",
                 i, out_valid, out_sel, out_alu, out_pc4, out_rd,
                 i, a, a + 32'd4, i + 1);
      end
    end
    drive(1'b0, 32'h0, 32'h0, 2'd0, 1'b0, 1'b0, 1'b0, 5'd0);
    tick();
    n_cmp++;
    if (out_valid !== 1'b0 || out_reg_write !== 1'b0 || out_imm !== 32'h00A30000) begin
      n_bad++;
      $display("FAIL b2b_end: got %b %b %h want 0 0 00a30000",
               out_valid, out_reg_write, out_imm);
    end
  endtask

`ifdef MIPS_MEM_TIMEOUT_EN
  task automatic test_timeout();
    int reqs;
    reqs = 0;
    drive(1'b1, 32'h400, 32'h0, WB_SEL_MEM, 1'b1, 1'b0, 1'b1, 5'd2);
    tick();
    drive(1'b0, 32'h0, 32'h0, 2'd0, 1'b0, 1'b0, 1'b0, 5'd0);
    while (dmem_req === 1'b1 && reqs < 20) begin
      reqs++;
      tick();
    end
    n_cmp++;
    if (reqs !== 8) begin
      n_bad++;
      $display("FAIL to_len: got %0d want 8", reqs);
    end
    n_cmp++;
    if ({out_valid, out_reg_write, mem_err} !== 3'b101) begin
      n_bad++;
      $display("FAIL to_pulse: got %b want 101",
               {out_valid, out_reg_write, mem_err});
    end
    tick();
    tick();
    n_cmp++;
    if (mem_err !== 1'b1 || in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL to_sticky: got %b %b want 1 1", mem_err, in_ready);
    end
  endtask
`else
  task automatic test_no_timeout();
    n_cmp++;
    if (mem_err !== 1'b0) begin
      n_bad++;
      $display("FAIL no_err: got %b want 0", mem_err);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_alu_op();
    test_load_wait();
    test_store_fast();
    test_rw_both();
    test_idle_ack();
    test_reset_wait();
    test_back_to_back();
`ifdef MIPS_MEM_TIMEOUT_EN
    test_timeout();
`else
    test_no_timeout();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_wb_stage.md
Name: mem_wb_stage

Overview:
- Memory-access stage of the MIPS pipeline, directly upstream of the 32-bit 4:1 writeback select mux.
- Accepts one EX/MEM result per handshake and performs any load/store through a variable-latency data-memory req/ack interface.
- Registers the four writeback candidates (ALU result, load data, PC+4, upper immediate) plus the 2-bit select that drives the mux's A/B/C/D inputs and its sel input.

Parameters:
- TIMEOUT_CYCLES, 255: request cycles before abort. Used only with MEM_TIMEOUT_EN.

Ports:
- clk  in  1  pipeline clock; all state updates on its rising edge
- rst_n  in  1  synchronous, active-low reset
- in_valid  in  1  upstream presents an instruction
- in_ready  out  1  stage can accept this cycle
- in_alu_result  in  32  ALU result / memory address
- in_store_data  in  32  store data
- in_pc_plus4  in  32  link value
- in_imm_upper  in  32  LUI value
- in_wb_sel  in  2  writeback select
- in_mem_read  in  1  load
- in_mem_write  in  1  store
- in_reg_write  in  1  register-file write enable
- in_rd  in  5  destination register
- dmem_req  out  1  memory request, held until ack
- dmem_we  out  1  1 = write
- dmem_addr  out  32  byte address
- dmem_wdata  out  32  write data
- dmem_ack  in  1  memory completes access this cycle
- dmem_rdata  in  32  read data, valid with ack
- out_valid  out  1  one-cycle pulse; outputs below valid
- out_alu  out  32  to mux A
- out_mem  out  32  to mux B
- out_pc4  out  32  to mux C
- out_imm  out  32  to mux D
- out_sel  out  2  to mux sel
- out_reg_write  out  1  gated: 0 whenever out_valid = 0
- out_rd  out  5  destination register
- mem_err  out  1  sticky timeout flag; constant 0 when MEM_TIMEOUT_EN is undefined

Behaviour:
- Reset (rst_n = 0 at a clk edge):
  - state = IDLE.
  - Every output register clears to 0: out_*, dmem_req, dmem_we, dmem_addr, dmem_wdata, mem_err.
- States: IDLE, MEM_WAIT.
- in_ready = (state == IDLE). Accept = in_valid & in_ready.
- IDLE, accept, no memory op:
  - Capture the payload into the out_* registers.
  - out_valid = 1 next cycle (latency 1). out_mem = 0.
- IDLE, accept, memory op:
  - Capture the payload.
  - Next cycle: dmem_req = 1, dmem_addr = in_alu_result, dmem_we = in_mem_write, dmem_wdata = in_store_data.
  - Go to MEM_WAIT. out_valid stays 0.
- in_mem_read and in_mem_write both 1: treated as a store; read ignored; out_mem = 0.
- MEM_WAIT:
  - dmem_req and the address/data/we outputs are held stable until ack.
  - Ack may arrive in the first request cycle.
  - On ack: dmem_req = 0 next cycle; out_mem = dmem_rdata for a load, 0 for a store; out_valid = 1 next cycle; return to IDLE.
  - Load latency = 2 + wait cycles.
- Back-to-back: a new instruction can be accepted in the same cycle that out_valid is pulsing, because state is IDLE then.
- dmem_ack while in IDLE: ignored.
- Reset during MEM_WAIT:
  - Next edge: state = IDLE, dmem_req = 0, no out_valid.
  - A late ack is ignored.
- Between pulses: out_valid = 0 and out_reg_write = 0. Data outputs hold their last values.
- No alignment checking. dmem_addr[1:0] passes through unchanged.

Optional Feature:
- MIPS_MEM_TIMEOUT_EN defined:
  - A counter clears on entry to MEM_WAIT and increments on each req cycle without ack.
  - At TIMEOUT_CYCLES: drop dmem_req, set mem_err (sticky until reset), pulse out_valid with out_reg_write = 0, return to IDLE.
- Undefined: no counter; the stage waits indefinitely; mem_err tied 0.

Decomposition:
- mips_pkg holds:
  - WB_SEL_ALU = 2'd0, WB_SEL_MEM = 2'd1, WB_SEL_PC4 = 2'd2, WB_SEL_IMM = 2'd3 (these match the mux input order A–D).
  - The state enum {IDLE, MEM_WAIT}.
- One natural sub-module: dmem_timeout_ctr (counter plus compare), instantiated only under MIPS_MEM_TIMEOUT_EN.

Test Plan:
- ALU op: in_alu_result = 0x00000010, wb_sel = 0, reg_write = 1, rd = 5 -> next cycle out_valid = 1, out_alu = 0x10, out_sel = 0, out_rd = 5, out_reg_write = 1; one cycle later out_reg_write = 0.
- Load, ack after 3 cycles: address 0x100, rdata = 0xDEADBEEF -> dmem_req high for exactly 3 cycles; out_mem = 0xDEADBEEF, out_sel = 1; in_ready = 0 throughout MEM_WAIT.
- Store with ack in the first req cycle: address 0x104, data 0x12345678 -> dmem_we = 1, dmem_wdata = 0x12345678; out_valid 2 cycles after accept; out_mem = 0.
- Reset asserted on the 2nd MEM_WAIT cycle, ack arriving afterwards -> dmem_req = 0, no out_valid, next accept works normally.
- Back-to-back ALU ops on 4 consecutive cycles (wb_sel 0, 1, 2, 3 with distinct values) -> 4 consecutive out_valid pulses with matching data and out_sel.
- MIPS_MEM_TIMEOUT_EN defined, TIMEOUT_CYCLES = 8, ack never asserted -> req drops after 8 cycles, mem_err = 1 and stays 1, out_valid pulse with out_reg_write = 0.
